// File: rtl/btb_update_sequencer_if.sv
// ---------------------------------------------------------------------------
// btb_update_sequencer_if
//
// Purpose: bundles the resolve handshake, the checkpoint request/ack pair
// and the BTB update bus of btb_update_sequencer into one interface.
//
// Signals:
//   resolve_valid_i / resolve_pc_i / resolve_target_i : update offered
//   resolve_ready_o                                     : update accepted
//   ckpt_req_i / ckpt_mode_i                            : bank switch request
//   ckpt_ack_o                                          : switch complete pulse
//   checkpoint_mode_o                                   : bank select to BTB mux
//   btb_update_o                                        : {valid, pc, target_address}
//
// Modports: master drives the requests, slave is the sequencer.
// ---------------------------------------------------------------------------
interface btb_update_sequencer_if #(
   parameter int unsigned VLEN = 64
);
   typedef struct packed {
      logic            valid;
      logic [VLEN-1:0] pc;
      logic [VLEN-1:0] target_address;
   } btb_update_t;

   logic            resolve_valid_i;
   logic [VLEN-1:0] resolve_pc_i;
   logic [VLEN-1:0] resolve_target_i;
   logic            resolve_ready_o;
   logic            ckpt_req_i;
   logic            ckpt_mode_i;
   logic            ckpt_ack_o;
   logic            checkpoint_mode_o;
   btb_update_t     btb_update_o;

   modport master (
      output resolve_valid_i, resolve_pc_i, resolve_target_i, ckpt_req_i, ckpt_mode_i,
      input  resolve_ready_o, ckpt_ack_o, checkpoint_mode_o, btb_update_o
   );

   modport slave (
      input  resolve_valid_i, resolve_pc_i, resolve_target_i, ckpt_req_i, ckpt_mode_i,
      output resolve_ready_o, ckpt_ack_o, checkpoint_mode_o, btb_update_o
   );
endinterface

// File: rtl/btb_update_sequencer.sv
// ---------------------------------------------------------------------------
// btb_update_sequencer
//
// Purpose: buffers resolved taken-branch updates in a small FIFO and feeds
// them to the BTB one per cycle. A checkpoint request for a different
// predictor bank stops intake, drains the FIFO, flips the bank select, waits
// one settle cycle for the BTB mux register, then acknowledges.
//
// Ports:
//   clk_i        : clock, all state on rising edge
//   rst_i        : synchronous active-high reset
//   flush_i      : discard all pending updates
//   debug_mode_i : accepted updates are dropped while high
//   bus          : resolve handshake, checkpoint req/ack, BTB update bus
// ---------------------------------------------------------------------------
module btb_update_sequencer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned VLEN  = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   input  logic                    debug_mode_i,
   btb_update_sequencer_if.slave   bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             mode_q, mode_d;
   logic             target_q, target_d;
   logic             ack_q, ack_d;
   // Set by an ack, cleared once ckpt_req_i has been seen low.
   logic             block_q, block_d;

   logic [VLEN-1:0]  pc_mem_q  [DEPTH];
   logic [VLEN-1:0]  tgt_mem_q [DEPTH];

   logic [PTR_W-1:0] tail_last;
   logic             ckpt_pending;
   logic             ready;
   logic             pop;
   logic             accept;
   logic             store;
   logic             coalesce;
   logic             push;
   logic             ack_fire;

   assign tail_last    = tail_q - PTR_W'(1);
   assign ckpt_pending = bus.ckpt_req_i & (bus.ckpt_mode_i != mode_q);
   assign ready        = (state_q == ST_RUN) & (count_q < CNT_W'(DEPTH)) & ~ckpt_pending;

   // Downstream never stalls: whatever is presented is consumed.
   assign pop    = (count_q != '0) & ((state_q == ST_RUN) | (state_q == ST_DRAIN)) & ~flush_i;
   assign accept = bus.resolve_valid_i & ready;
   assign store  = accept & ~debug_mode_i & ~flush_i;

   // Only merge into the tail when that entry survives this cycle.
   assign coalesce = store & (count_q != '0)
                   & (pc_mem_q[tail_last] == bus.resolve_pc_i)
                   & ~(pop & (count_q == CNT_W'(1)));
   assign push     = store & ~coalesce;

   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem_q[tail_q]  <= bus.resolve_pc_i;
         tgt_mem_q[tail_q] <= bus.resolve_target_i;
      end else if (coalesce) begin
         tgt_mem_q[tail_last] <= bus.resolve_target_i;
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PTR_W'(pop);
         tail_d  = tail_q + PTR_W'(push);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      target_d = target_q;
      ack_fire = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (ckpt_pending & ~block_q) begin
               state_d  = ST_DRAIN;
               target_d = bus.ckpt_mode_i;
            end else if (bus.ckpt_req_i & ~ckpt_pending & ~block_q) begin
               // Already in the requested bank: acknowledge straight away.
               ack_fire = 1'b1;
            end
         end
         ST_DRAIN: begin
            // count_d already reflects this cycle's pop (or a flush).
            if (count_d == '0) begin
               mode_d  = target_q;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            state_d  = ST_RUN;
            ack_fire = 1'b1;
         end
         default: state_d = ST_RUN;
      endcase
      ack_d   = ack_fire;
      block_d = ack_fire | (block_q & bus.ckpt_req_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_RUN;
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         mode_q   <= 1'b0;
         target_q <= 1'b0;
         ack_q    <= 1'b0;
         block_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         mode_q   <= mode_d;
         target_q <= target_d;
         ack_q    <= ack_d;
         block_q  <= block_d;
      end
   end

   assign bus.resolve_ready_o   = ready;
   assign bus.ckpt_ack_o        = ack_q;
   assign bus.checkpoint_mode_o = mode_q;

   always_comb begin
      bus.btb_update_o.valid          = 1'b0;
      bus.btb_update_o.pc             = '0;
      bus.btb_update_o.target_address = '0;
      if (pop) begin
         bus.btb_update_o.valid          = 1'b1;
         bus.btb_update_o.pc             = pc_mem_q[head_q];
         bus.btb_update_o.target_address = tgt_mem_q[head_q];
      end
   end
endmodule

// File: tb/tb_btb_update_sequencer.sv
module tb_btb_update_sequencer;
   localparam int DEPTH = 4;
   localparam int VLEN  = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, flush, dbg;
   btb_update_sequencer_if #(.VLEN(VLEN)) bus ();

   btb_update_sequencer #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .debug_mode_i (dbg),
      .bus          (bus.slave)
   );

   // Reference model: pending updates as a queue, plus the checkpoint phase.
   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] tgt;
   } ent_t;

   ent_t mq[$];
   int   m_phase;     // 0 = running, 1 = draining, 2 = settling
   bit   m_mode, m_target, m_ack, m_block, last_ack;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_phase = 0; m_mode = 0; m_target = 0; m_ack = 0; m_block = 0; last_ack = 0;
   endtask

   // One clock cycle: drive at negedge, check 1ns later, advance the model.
   task automatic cyc(input bit r, input bit f, input bit d, input bit v,
                      input logic [63:0] pc, input logic [63:0] tgt,
                      input bit rq, input bit md);
      bit pend, rdy, vld, st, coal, fire;
      @(negedge clk);
      rst = r; flush = f; dbg = d;
      bus.resolve_valid_i  = v;
      bus.resolve_pc_i     = pc;
      bus.resolve_target_i = tgt;
      bus.ckpt_req_i       = rq;
      bus.ckpt_mode_i      = md;
      #1;
      if (r) begin
         model_reset();
      end else begin
         pend = rq && (md != m_mode);
         rdy  = (m_phase == 0) && (mq.size() < DEPTH) && !pend;
         vld  = (mq.size() != 0) && (m_phase != 2) && !f;
         chk("ready", 64'(bus.resolve_ready_o), 64'(rdy));
         chk("upd_valid", 64'(bus.btb_update_o.valid), 64'(vld));
         chk("upd_pc", bus.btb_update_o.pc, vld ? mq[0].pc : 64'h0);
         chk("upd_tgt", bus.btb_update_o.target_address, vld ? mq[0].tgt : 64'h0);
         chk("mode", 64'(bus.checkpoint_mode_o), 64'(m_mode));
         chk("ack", 64'(bus.ckpt_ack_o), 64'(m_ack));
         if (bus.btb_update_o.valid)
            $display("update pc=%0h tgt=%0h mode=%0d", bus.btb_update_o.pc,
                     bus.btb_update_o.target_address, bus.checkpoint_mode_o);
         last_ack = m_ack;

         st = v && rdy && !d && !f;
         if (f) begin
            mq.delete();
         end else begin
            coal = st && (mq.size() >= 1) && (mq[mq.size()-1].pc == pc)
                   && !(vld && mq.size() == 1);
            if (coal) mq[mq.size()-1].tgt = tgt;
            if (vld) void'(mq.pop_front());
            if (st && !coal) mq.push_back('{pc: pc, tgt: tgt});
         end

         fire = 0;
         case (m_phase)
            0: begin
               if (pend && !m_block) begin
                  m_phase = 1; m_target = md;
               end else if (rq && !pend && !m_block) begin
                  fire = 1;
               end
            end
            1: if (mq.size() == 0) begin
               m_mode = m_target; m_phase = 2;
            end
            default: begin
               m_phase = 0; fire = 1;
            end
         endcase
         m_ack   = fire;
         m_block = fire || (m_block && rq);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 64'h0, 64'h0, 0, 0);
   endtask

   // Hold a checkpoint request until ack (or reset), optionally keeping it
   // high for extra cycles afterwards; flush/reset can be injected at a cycle.
   task automatic ckpt(input bit md, input int flush_at, input int rst_at, input int hold_extra);
      bit seen = 0;
      bit was_rst = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(i == rst_at, i == flush_at, 0, 1, 64'h500 + 64'(i), 64'h900 + 64'(i), 1, md);
         if (i == rst_at) begin was_rst = 1; break; end
         if (last_ack) begin seen = 1; break; end
      end
      chk("ckpt_ack_seen", 64'(seen | was_rst), 64'h1);
      if (seen) begin
         $display("ckpt ack mode=%0d", bus.checkpoint_mode_o);
         for (int i = 0; i < hold_extra; i++) cyc(0, 0, 0, 0, 64'h0, 64'h0, 1, md);
      end
      cyc(0, 0, 0, 0, 64'h0, 64'h0, 0, 0);
   endtask

   initial begin
      bit req_on, req_md;
      rst = 1; flush = 0; dbg = 0;
      bus.resolve_valid_i = 0; bus.resolve_pc_i = '0; bus.resolve_target_i = '0;
      bus.ckpt_req_i = 0; bus.ckpt_mode_i = 0;
      model_reset();

      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 64'h0, 64'h0, 0, 0);
      idle(2);

      // Single push into an empty FIFO.
      cyc(0, 0, 0, 1, 64'h100, 64'h200, 0, 0);
      idle(3);

      // Four back-to-back distinct pushes.
      cyc(0, 0, 0, 1, 64'h10, 64'h110, 0, 0);
      cyc(0, 0, 0, 1, 64'h20, 64'h120, 0, 0);
      cyc(0, 0, 0, 1, 64'h30, 64'h130, 0, 0);
      cyc(0, 0, 0, 1, 64'h40, 64'h140, 0, 0);
      idle(3);

      // Same pc twice in a row.
      cyc(0, 0, 0, 1, 64'h100, 64'h200, 0, 0);
      cyc(0, 0, 0, 1, 64'h100, 64'h300, 0, 0);
      idle(3);

      // Debug mode drops accepted updates.
      cyc(0, 0, 1, 1, 64'h700, 64'h800, 0, 0);
      idle(2);

      // Same-mode request: immediate ack, no mode change.
      ckpt(0, -1, -1, 0);
      idle(2);

      // Switch to bank B with traffic queued.
      cyc(0, 0, 0, 1, 64'h180, 64'h280, 0, 0);
      ckpt(1, -1, -1, 0);
      idle(2);

      // Request held high after ack: no second ack.
      ckpt(1, -1, -1, 4);
      idle(2);

      // Flush during drain back to bank A.
      cyc(0, 0, 0, 1, 64'h1a0, 64'h2a0, 0, 0);
      ckpt(0, 1, -1, 0);
      idle(2);

      // Reset in the middle of a switch abandons it.
      cyc(0, 0, 0, 1, 64'h1c0, 64'h2c0, 0, 0);
      ckpt(1, -1, 1, 0);
      idle(3);

      // Randomised traffic.
      req_on = 0; req_md = 0;
      for (int i = 0; i < 3000; i++) begin
         bit r, f, d, v;
         if (req_on && last_ack) req_on = 0;
         else if (!req_on && ($urandom % 20 == 0)) begin
            req_on = 1; req_md = 1'($urandom % 2);
         end
         r = ($urandom % 600 == 0);
         f = ($urandom % 25 == 0);
         d = ($urandom % 15 == 0);
         v = ($urandom % 3 != 0);
         if (r) req_on = 0;
         cyc(r, f, d, v, 64'h1000 + 64'(($urandom % 4) * 4), {32'h0, $urandom},
             req_on, req_md);
      end
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/btb_update_sequencer.md
BTB_UPDATE_SEQUENCER -- requirements
Module: btb_update_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, pending-update FIFO depth (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush_i  input  1  discard all pending updates.
REQ-005 SHALL have port debug_mode_i  input  1  drop incoming updates while high.
REQ-006 SHALL have port resolve_valid_i  input  1  resolved taken-branch update offered.
REQ-007 SHALL have port resolve_pc_i  input  riscv::VLEN  branch PC.
REQ-008 SHALL have port resolve_target_i  input  riscv::VLEN  branch target.
REQ-009 SHALL have port resolve_ready_o  output  1  update accepted when valid&ready.
REQ-010 SHALL have port ckpt_req_i  input  1  level request to move to mode ckpt_mode_i; held until ack.
REQ-011 SHALL have port ckpt_mode_i  input  1  requested predictor bank (0=A, 1=B).
REQ-012 SHALL have port ckpt_ack_o  output  1  one-cycle pulse, switch complete.
REQ-013 SHALL have port checkpoint_mode_o  output  1  registered bank select to BTB mux.
REQ-014 SHALL have port btb_update_o  output  ariane_pkg::btb_update_t  update to BTB mux (valid, pc, target_address).

Function
REQ-015 SHALL hold updates in a DEPTH-entry FIFO with head/tail pointers wrapping modulo DEPTH and a count of width clog2(DEPTH)+1.
REQ-016 SHALL implement FSM states RUN, DRAIN, SETTLE; reset state RUN.
REQ-017 SHALL drive resolve_ready_o = (state==RUN) & (count<DEPTH) & !ckpt_pending, where ckpt_pending = ckpt_req_i & (ckpt_mode_i!=checkpoint_mode_o).
REQ-018 SHALL, on accept with debug_mode_i=1, consume the update without storing it.
REQ-019 SHALL, on accept when count>=1 and tail entry pc equals resolve_pc_i and tail entry is not being popped that cycle, overwrite the tail target instead of pushing (coalesce).
REQ-020 SHALL otherwise push the update at tail.
REQ-021 SHALL drive btb_update_o.valid = (count!=0) & state in {RUN, DRAIN}, pc/target_address from head; '0 fields when not valid.
REQ-022 SHALL pop the head every cycle btb_update_o.valid=1 (downstream never stalls).
REQ-023 SHALL present an update accepted in cycle N on btb_update_o in cycle N+1 when the FIFO was empty.
REQ-024 SHALL handle simultaneous push and pop with count unchanged, including at count==DEPTH-1 and count==1.
REQ-025 SHALL, in RUN with ckpt_pending, move to DRAIN.
REQ-026 SHALL, in DRAIN, keep popping; when count reaches 0 (after the pop), toggle checkpoint_mode_o to ckpt_mode_i next edge and move to SETTLE.
REQ-027 SHALL, in SETTLE, wait exactly one cycle (BTB mux update register commits), then pulse ckpt_ack_o and return to RUN.
REQ-028 SHALL, when ckpt_req_i=1 and ckpt_mode_i==checkpoint_mode_o in RUN, pulse ckpt_ack_o the following cycle with no drain and no mode change.
REQ-029 SHALL, on flush_i, empty the FIFO (count=0, pointers 0) at the next edge and suppress btb_update_o.valid that cycle; a concurrent accept is discarded.
REQ-030 SHALL, on flush_i during DRAIN, proceed to the mode toggle at the next edge.
REQ-031 SHALL not issue a second ack until ckpt_req_i has been low for at least one cycle.

Reset
REQ-032 SHALL, while rst_i=1, set state=RUN, count=0, pointers=0, checkpoint_mode_o=0, ckpt_ack_o=0, btb_update_o='0; resolve_ready_o=1 from the first cycle after reset.
REQ-033 SHALL abandon any drain or switch in progress on reset without acking.

Verification
REQ-034 Push pc=0x100/tgt=0x200 into empty FIFO cycle N -> btb_update_o valid pc=0x100 tgt=0x200 at N+1 only.
REQ-035 Four back-to-back distinct pushes with DEPTH=4 -> four in-order updates on consecutive cycles; ready never drops.
REQ-036 Push pc=0x100 tgt=0x200 then pc=0x100 tgt=0x300 while head blocked by earlier entry -> single update tgt=0x300.
REQ-037 Two entries queued, ckpt_req_i=1 ckpt_mode_i=1 -> ready=0, two updates emitted, checkpoint_mode_o=1, SETTLE cycle, ack pulse, ready=1.
REQ-038 ckpt_req_i with ckpt_mode_i=0 while mode=0 -> ack next cycle, mode unchanged.
REQ-039 flush_i with three entries queued during DRAIN -> no further updates, mode toggles next edge, ack after SETTLE.
